alu_seq_ctrl: RTL and testbench
===============================

// Module: alu_seq_ctrl
// PURPOSE
//  Sequencer that shares the 8-bit ALU (AND/XOR/ADD/circular-shift-left) with an instruction stream.
//  Accepts one instruction per valid/ready handshake and reads two operands from an internal register file.
//  Drives the ALU operand and select buses, then writes the result back and latches the CO and Z flags.
//  Sits between the instruction source and the ALU; the ALU stays purely combinational outside this block.
// PARAMETERS
//  DW  8  datapath width; must match ALU width
//  AW  2  register-file address width (2**AW registers)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  ins_valid  in   1      instruction present on ins_word
//  ins_ready  out  1      controller can accept an instruction
//  ins_word   in   3*AW+3 [1:0]=op (00 AND,01 XOR,10 ADD,11 SHL), [2+:AW]=dst, [2+AW+:AW]=srcA, [2+2AW+:AW]=srcB, MSB=cond
//  ld_en      in   1      external register load strobe
//  ld_addr    in   AW     load address
//  ld_data    in   DW     load data
//  alu_a      out  DW     ALU operand A
//  alu_b      out  DW     ALU operand B
//  alu_sel    out  2      ALU instruction select
//  alu_out    in   DW     ALU result
//  alu_co     in   1      ALU carry out
//  alu_z      in   1      ALU zero flag
//  done       out  1      one-cycle pulse: instruction retired
//  result     out  DW     last written-back value
//  flag_c     out  1      latched carry flag
//  flag_z     out  1      latched zero flag
// BEHAVIOUR
//  - Reset (async; clears immediately and holds while rst=1): state=IDLE, all registers=0, alu_a/alu_b/alu_sel=0, done=0, result=0, flags=0, ins_ready=0.
//  - FSM: IDLE -> READ -> EXEC -> WB -> IDLE, with no other transitions.
//  - IDLE: ins_ready=1. ins_valid&ins_ready at edge 0 captures ins_word and moves to READ. ins_valid alone does nothing.
//  - READ (cycle 1): alu_a<=rf[srcA], alu_b<=rf[srcB], alu_sel<=op. These are registered outputs and stay stable until the next READ.
//  - EXEC (cycle 2): alu_out/alu_co/alu_z are sampled at the end of the cycle into result_nxt/c_nxt/z_nxt.
//  - WB (cycle 3): rf[dst]<=result_nxt, result<=result_nxt, flag_c<=c_nxt, flag_z<=z_nxt at the end of the cycle. done=1 for this cycle only.
//  - Timing: ins_ready goes high again in cycle 4. Throughput is 1 instruction per 4 cycles. ins_ready=0 in READ/EXEC/WB.
//  - srcA, srcB and dst may alias. Operands are the values before writeback (read in READ, written in WB).
//  - ld_en: honoured only in IDLE and with rst=0; rf[ld_addr]<=ld_data. Ignored in other states.
//  - Simultaneous ld_en and instruction accept in IDLE: the load takes effect that edge, so the instruction sees the loaded value.
//  - Flags: taken verbatim from the ALU. AND/XOR give C=0. SHL gives C=bit0 of the rotated result. ADD carry is the 9th bit; the sum wraps modulo 2**DW.
//  - Reset mid-operation (any state): abort immediately. The register file is cleared and done does not pulse.
//  - The cond bit is ignored unless COND_EXEC_EN is defined.
// CONFIGURATION
//  COND_EXEC_EN defined:
//   - An instruction with cond=1 executes only if flag_z=1, where flag_z is sampled in READ.
//   - Otherwise it is skipped: still walks READ/EXEC/WB and done still pulses, but rf, result and flags are unchanged.
//  COND_EXEC_EN undefined:
//   - The cond bit is ignored and every instruction executes.
// TESTING
//  T1 load r0=0x0F, r1=0xF3; AND r2=r0,r1 -> done in cycle 3, r2=result=0x03, C=0, Z=0
//  T2 r1=0xF3; ADD r3=r1,r1 -> result=0xE6, C=1, Z=0; alu_sel=10 during EXEC
//  T3 r0=0x0F; XOR r0=r0,r0 -> r0=0x00, Z=1, C=0; a subsequent ADD r2=r0,r0 reads 0x00
//  T4 load r1=0x81; SHL r2=r1 -> result=0x03, C=1; SHL r2=r2 -> 0x06, C=0
//  T5 hold ins_valid=1 for 10 cycles with the same word -> exactly 3 accepts (cycles 0, 4, 8); ins_ready low in between; ld_en in EXEC is ignored
//  T6 assert rst during EXEC -> outputs/rf=0 same cycle, no done; after release ins_ready=1 and a fresh AND works
//  T7 (COND_EXEC_EN) flag_z=0, cond=1 ADD -> done pulses, rf and flags unchanged; after XOR sets Z=1, cond=1 ADD executes

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Four-phase sequencer (IDLE/READ/EXEC/WB) driving an external combinational 8-bit ALU.
// Optional conditional execution is enabled with `define COND_EXEC_EN.
module alu_seq_ctrl #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ins_valid,
  output logic              ins_ready,
  input  logic [3*AW+2:0]   ins_word,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DW-1:0]     ld_data,
  output logic [DW-1:0]     alu_a,
  output logic [DW-1:0]     alu_b,
  output logic [1:0]        alu_sel,
  input  logic [DW-1:0]     alu_out,
  input  logic              alu_co,
  input  logic              alu_z,
  output logic              done,
  output logic [DW-1:0]     result,
  output logic              flag_c,
  output logic              flag_z
);

  localparam int unsigned IW = 3 * AW + 3;
  localparam int unsigned NR = 1 << AW;

  typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ins_q;
  logic [DW-1:0]   rf_q [NR];
  logic [DW-1:0]   alu_a_q, alu_b_q;
  logic [1:0]      alu_sel_q;
  logic [DW-1:0]   result_nxt_q;
  logic            c_nxt_q, z_nxt_q;
  logic [DW-1:0]   result_q;
  logic            flag_c_q, flag_z_q;
  logic            wb_en;
  logic            accept;

  logic [1:0]      op;
  logic [AW-1:0]   dst, src_a, src_b;

  assign op    = ins_q[1:0];
  assign dst   = ins_q[2 +: AW];
  assign src_a = ins_q[2 + AW +: AW];
  assign src_b = ins_q[2 + 2 * AW +: AW];

`ifdef COND_EXEC_EN
  // Predicate is resolved against flag_z as it stands during READ.
  logic skip_q;
  assign wb_en = ~skip_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skip_q <= 1'b0;
    end else if (state_q == StRead) begin
      skip_q <= ins_q[IW-1] & ~flag_z_q;
    end
  end
`else
  logic unused_cond;
  assign unused_cond = ins_q[IW-1];
  assign wb_en       = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (ins_valid) state_d = StRead;
      StRead:  state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign accept    = (state_q == StIdle) & ins_valid;
  assign ins_ready = (state_q == StIdle) & ~rst;
  assign done      = (state_q == StWb);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      ins_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      result_nxt_q <= '0;
      c_nxt_q      <= 1'b0;
      z_nxt_q      <= 1'b0;
      result_q     <= '0;
      flag_c_q     <= 1'b0;
      flag_z_q     <= 1'b0;
      for (int i = 0; i < NR; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) ins_q <= ins_word;
      // Loads land on the accept edge, so the captured instruction sees them in READ.
      if ((state_q == StIdle) && ld_en) rf_q[ld_addr] <= ld_data;
      if (state_q == StRead) begin
        alu_a_q   <= rf_q[src_a];
        alu_b_q   <= rf_q[src_b];
        alu_sel_q <= op;
      end
      if (state_q == StExec) begin
        result_nxt_q <= alu_out;
        c_nxt_q      <= alu_co;
        z_nxt_q      <= alu_z;
      end
      if ((state_q == StWb) && wb_en) begin
        rf_q[dst] <= result_nxt_q;
        result_q  <= result_nxt_q;
        flag_c_q  <= c_nxt_q;
        flag_z_q  <= z_nxt_q;
      end
    end
  end

  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_sel = alu_sel_q;
  assign result  = result_q;
  assign flag_c  = flag_c_q;
  assign flag_z  = flag_z_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: provides the ALU, runs directed vectors,
// multi-cycle corner sequences and randomized instructions against a register-file model.
module tb_alu_seq_ctrl;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int IW = 3 * AW + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ins_valid = 1'b0;
  logic          ins_ready;
  logic [IW-1:0] ins_word = '0;
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic [DW-1:0] alu_a, alu_b, alu_out, result;
  logic [1:0]    alu_sel;
  logic          alu_co, alu_z, done, flag_c, flag_z;

  alu_seq_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_word(ins_word),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sel(alu_sel), .alu_out(alu_out), .alu_co(alu_co), .alu_z(alu_z), .done(done),
    .result(result), .flag_c(flag_c), .flag_z(flag_z)
  );

  always #5 clk = ~clk;

  // Returns {carry, zero, result}.
  function automatic logic [9:0] alu_fn(input logic [1:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic       c;
    case (op)
      2'd0:    begin r = a & b; c = 1'b0; end
      2'd1:    begin r = a ^ b; c = 1'b0; end
      2'd2:    begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
      default: begin r = {a[6:0], a[7]}; c = r[0]; end
    endcase
    return {c, (r == 8'h00), r};
  endfunction

  always_comb {alu_co, alu_z, alu_out} = alu_fn(alu_sel, alu_a, alu_b);

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  logic [7:0] mrf [4];
  logic [7:0] m_res;
  logic       m_c, m_z;

  function automatic logic [IW-1:0] mk(input logic [1:0] op, input logic [1:0] dst,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic cond);
    return {cond, sb, sa, dst, op};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mrf[i] = 8'h00;
    m_res = 8'h00; m_c = 1'b0; m_z = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!ins_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk({tag, ".ready_wait"}, ins_ready, 1);
  endtask

  task automatic load(input logic [1:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
    mrf[a] = d;
  endtask

  // Issues one instruction from IDLE and follows it to the next IDLE cycle.
  task automatic exec_ins(input logic [IW-1:0] w, input bit ld, input logic [1:0] la,
                          input logic [7:0] ldd, input bit use_exp, input logic [7:0] er,
                          input bit ec, input bit ez, input string tag);
    logic [1:0] op, dst, sa, sb;
    logic [7:0] ea, eb;
    logic [9:0] m;
    bit         skip;
    op = w[1:0]; dst = w[3:2]; sa = w[5:4]; sb = w[7:6];
    wait_ready(tag);
    if (ld) mrf[la] = ldd;
    ea = mrf[sa]; eb = mrf[sb];
    m  = alu_fn(op, ea, eb);
    if (use_exp) m = {ec, ez, er};
`ifdef COND_EXEC_EN
    skip = w[IW-1] & ~m_z;
`else
    skip = 1'b0;
`endif
    if (!skip) begin
      mrf[dst] = m[7:0]; m_res = m[7:0]; m_c = m[9]; m_z = m[8];
    end
    ins_word = w; ins_valid = 1'b1;
    ld_en = ld; ld_addr = la; ld_data = ldd;
    @(negedge clk);
    ins_valid = 1'b0; ld_en = 1'b0;
    chk({tag, ".ready_read"}, ins_ready, 0);
    chk({tag, ".done_read"}, done, 0);
    @(negedge clk);
    chk({tag, ".alu_a"}, alu_a, ea);
    chk({tag, ".alu_b"}, alu_b, eb);
    chk({tag, ".alu_sel"}, alu_sel, op);
    chk({tag, ".ready_exec"}, ins_ready, 0);
    @(negedge clk);
    chk({tag, ".done_wb"}, done, 1);
    chk({tag, ".ready_wb"}, ins_ready, 0);
    @(negedge clk);
    chk({tag, ".done_after"}, done, 0);
    chk({tag, ".ready_after"}, ins_ready, 1);
    chk({tag, ".result"}, result, m_res);
    chk({tag, ".flag_c"}, flag_c, m_c);
    chk({tag, ".flag_z"}, flag_z, m_z);
  endtask

  typedef struct {
    bit         ld;
    logic [1:0] la;
    logic [7:0] ldd;
    logic [1:0] op, dst, sa, sb;
    logic [7:0] res;
    bit         c, z;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         acc, dn;
    logic [9:0] rdy_mask;
    logic [IW-1:0] w;

    tbl[0] = '{1'b1, 2'd1, 8'hF3, 2'd0, 2'd2, 2'd0, 2'd1, 8'h03, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 2'd0, 8'h00, 2'd2, 2'd3, 2'd1, 2'd1, 8'hE6, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 2'd0, 8'h00, 2'd1, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 2'd0, 8'h00, 2'd2, 2'd2, 2'd0, 2'd0, 8'h00, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 2'd1, 8'h81, 2'd3, 2'd2, 2'd1, 2'd1, 8'h03, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 2'd0, 8'h00, 2'd3, 2'd2, 2'd2, 2'd2, 8'h06, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 2'd0, 8'h00, 2'd2, 2'd3, 2'd3, 2'd2, 8'hEC, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 2'd0, 8'h00, 2'd2, 2'd1, 2'd1, 2'd3, 8'h6D, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 2'd0, 8'h00, 2'd1, 2'd0, 2'd1, 2'd3, 8'h81, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 2'd0, 8'h00, 2'd0, 2'd3, 2'd2, 2'd1, 8'h04, 1'b0, 1'b0};

    // Reset state
    model_reset();
    #2;
    chk("rst.ready", ins_ready, 0);
    chk("rst.done", done, 0);
    chk("rst.outs", {alu_a, alu_b, alu_sel, result, flag_c, flag_z}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_rel.ready", ins_ready, 1);
    @(negedge clk);

    // Directed vectors
    load(2'd0, 8'h0F);
    for (int i = 0; i < 10; i++) begin
      exec_ins(mk(tbl[i].op, tbl[i].dst, tbl[i].sa, tbl[i].sb, 1'b0), tbl[i].ld, tbl[i].la,
               tbl[i].ldd, 1'b1, tbl[i].res, tbl[i].c, tbl[i].z, $sformatf("vec%0d", i));
    end

    // Held ins_valid: accepts in cycles 0, 4, 8; load during EXEC is dropped
    w = mk(2'd0, 2'd0, 2'd1, 2'd1, 1'b0);
    acc = 0; dn = 0; rdy_mask = '0;
    ins_word = w; ins_valid = 1'b1; ld_addr = 2'd1; ld_data = 8'h55;
    for (int i = 0; i < 10; i++) begin
      if (ins_ready) begin acc++; rdy_mask[i] = 1'b1; end
      if (done) dn++;
      ld_en = (i == 2);
      @(negedge clk);
    end
    ins_valid = 1'b0; ld_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (done) dn++;
      if (ins_ready) break;
      @(negedge clk);
    end
    mrf[0] = mrf[1]; m_res = mrf[1]; m_c = 1'b0; m_z = (mrf[1] == 8'h00);
    chk("hold.accepts", acc, 3);
    chk("hold.ready_mask", rdy_mask, 10'b01_0001_0001);
    chk("hold.dones", dn, 3);
    chk("hold.result", result, m_res);
    chk("hold.flag_z", flag_z, m_z);
    exec_ins(mk(2'd2, 2'd3, 2'd1, 2'd0, 1'b0), 1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0,
             "post_hold");

    // Reset asserted during EXEC
    wait_ready("rst_mid");
    ins_word = mk(2'd2, 2'd3, 2'd1, 2'd1, 1'b0); ins_valid = 1'b1;
    @(negedge clk);
    ins_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid.outs", {alu_a, alu_b, alu_sel, result, flag_c, flag_z}, 0);
    chk("rst_mid.ready", ins_ready, 0);
    chk("rst_mid.done", done, 0);
    @(negedge clk);
    chk("rst_mid.done_hold", done, 0);
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_mid.ready_rel", ins_ready, 1);
    @(negedge clk);
    chk("rst_mid.no_done", done, 0);
    exec_ins(mk(2'd2, 2'd2, 2'd1, 2'd3, 1'b0), 1'b0, 2'd0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1,
             "rf_cleared");
    load(2'd0, 8'h3C);
    load(2'd1, 8'hF0);
    exec_ins(mk(2'd0, 2'd2, 2'd0, 2'd1, 1'b0), 1'b0, 2'd0, 8'h00, 1'b1, 8'h30, 1'b0, 1'b0,
             "fresh_and");

    // Cond bit: skipped with COND_EXEC_EN while Z=0, ignored otherwise
    load(2'd0, 8'h01);
    load(2'd1, 8'h02);
    load(2'd3, 8'hA0);
    exec_ins(mk(2'd2, 2'd2, 2'd0, 2'd1, 1'b0), 1'b0, 2'd0, 8'h00, 1'b1, 8'h03, 1'b0, 1'b0,
             "cond_setup");
    exec_ins(mk(2'd2, 2'd3, 2'd0, 2'd1, 1'b1), 1'b0, 2'd0, 8'h00, 1'b1, 8'h03, 1'b0, 1'b0,
             "cond_z0");
    exec_ins(mk(2'd0, 2'd0, 2'd3, 2'd3, 1'b0), 1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0,
             "cond_readback");
    exec_ins(mk(2'd1, 2'd2, 2'd2, 2'd2, 1'b0), 1'b0, 2'd0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1,
             "cond_setz");
    exec_ins(mk(2'd2, 2'd3, 2'd1, 2'd1, 1'b1), 1'b0, 2'd0, 8'h00, 1'b1, 8'h04, 1'b0, 1'b0,
             "cond_z1");

    // Randomized traffic against the model
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        load(2'($urandom_range(0, 3)), 8'($urandom));
      end else begin
        exec_ins(IW'($urandom), 1'($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
                 8'($urandom), 1'b0, 8'h00, 1'b0, 1'b0, $sformatf("rnd%0d", i));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
